fifo_param: RTL and testbench

Parametrised synchronous FIFO, the next generation of the 10-bit, 8-entry push/pop FIFO used between the byte-level blocks of the datapath. Width and depth are set by parameters. Adds an occupancy counter, programmable almost-full/almost-empty thresholds, a registered read port with a valid strobe, defined simultaneous push/pop behaviour at the boundaries, and sticky overflow/underflow error flags. Sits between a producer and a consumer in one clock domain.

---
 rtl/fifo_param.sv | 115 +++++++++++
 tb/tb_fifo_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy counter,
// programmable almost-full/almost-empty thresholds, a registered read
// port with a one-cycle valid strobe and sticky overflow/underflow flags.
module fifo_param #(
  parameter int data_width    = 10,
  parameter int address_width = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [data_width-1:0]    FIFO_data_in,
  input  logic [address_width:0]   af_thresh,
  input  logic [address_width:0]   ae_thresh,
  input  logic                     clr_err,
  output logic [data_width-1:0]    FIFO_data_out,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [address_width:0]   fifo_count,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int DEPTH = 1 << address_width;
  // Occupancy value meaning "full", sized like the counter.
  localparam logic [address_width:0] DEPTH_C = {1'b1, {address_width{1'b0}}};

  logic [data_width-1:0]    mem [DEPTH];

  logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [address_width:0]   count_q, count_d;
  logic [data_width-1:0]    data_out_q, data_out_d;
  logic                     valid_q, valid_d;
  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;

  logic                     push_ok;
  logic                     pop_ok;

  // Status flags come only from the registered count so they cannot glitch
  // on request inputs; thresholds are unsigned compares.
  assign full          = (count_q == DEPTH_C);
  assign empty         = (count_q == '0);
  assign almost_full   = (count_q >= af_thresh);
  assign almost_empty  = (count_q <= ae_thresh);
  assign fifo_count    = count_q;
  assign FIFO_data_out = data_out_q;
  assign data_valid    = valid_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;

  // Accept decisions on pre-edge state; a pop frees a slot for a push when full.
  always_comb begin
    push_ok = push & (~full | pop);
    pop_ok  = pop & ~empty;
  end

  // Next-state for pointers, count, read port and error flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = pop_ok;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem[rd_ptr_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // clr_err takes priority over an error raised in the same cycle.
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      ovf_d = ovf_q | (push & full & ~pop);
      udf_d = udf_q | (pop & empty);
    end
  end

  // Storage array: written on accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= FIFO_data_in;
  end

  // Control and read-port registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: table-driven directed checks for fifo_param plus
// hand-written sequences for thresholds and mid-stream reset.
module tb_fifo_param;

  logic        clk;
  logic        reset;
  logic        push;
  logic        pop;
  logic [9:0]  din;
  logic [3:0]  af_thresh;
  logic [3:0]  ae_thresh;
  logic        clr_err;
  logic [9:0]  dout;
  logic        data_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  fifo_count;
  logic        overflow_err;
  logic        underflow_err;

  int n_tests;
  int n_fail;

  fifo_param #(.data_width(10), .address_width(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .FIFO_data_in (din),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .clr_err      (clr_err),
    .FIFO_data_out(dout),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic [9:0] din;
    logic       clr;
    int         cnt;
    logic [9:0] dout;
    logic       valid;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs [80];
  int   nv;

  task automatic add(input logic p, input logic q, input logic [9:0] d, input logic c,
                     input int cnt, input logic [9:0] o, input logic v,
                     input logic ov, input logic ud);
    vecs[nv].push  = p;
    vecs[nv].pop   = q;
    vecs[nv].din   = d;
    vecs[nv].clr   = c;
    vecs[nv].cnt   = cnt;
    vecs[nv].dout  = o;
    vecs[nv].valid = v;
    vecs[nv].ovf   = ov;
    vecs[nv].udf   = ud;
    nv++;
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Compare every output against one record; flags follow from the expected
  // count and the thresholds in force (af=6, ae=1 during the table).
  task automatic check_vec(input int i, input vec_t v);
    check("fifo_count", i, int'(fifo_count), v.cnt);
    check("full", i, int'(full), int'(v.cnt == 8));
    check("empty", i, int'(empty), int'(v.cnt == 0));
    check("almost_full", i, int'(almost_full), int'(v.cnt >= 6));
    check("almost_empty", i, int'(almost_empty), int'(v.cnt <= 1));
    check("data_out", i, int'(dout), int'(v.dout));
    check("data_valid", i, int'(data_valid), int'(v.valid));
    check("overflow_err", i, int'(overflow_err), int'(v.ovf));
    check("underflow_err", i, int'(underflow_err), int'(v.udf));
    $display("[TB] vec %0d push=%0d pop=%0d din=%03h clr=%0d -> cnt=%0d dout=%03h v=%0d ovf=%0d udf=%0d",
             i, v.push, v.pop, v.din, v.clr, fifo_count, dout, data_valid,
             overflow_err, underflow_err);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nv      = 0;

    // Fill and drain order.
    add(1,0,10'h090,0, 1,10'h000,0,0,0);
    add(1,0,10'h1A9,0, 2,10'h000,0,0,0);
    add(1,0,10'h239,0, 3,10'h000,0,0,0);
    add(1,0,10'h04F,0, 4,10'h000,0,0,0);
    add(1,0,10'h04D,0, 5,10'h000,0,0,0);
    add(1,0,10'h018,0, 6,10'h000,0,0,0);
    add(0,1,10'h000,0, 5,10'h090,1,0,0);
    add(0,1,10'h000,0, 4,10'h1A9,1,0,0);
    add(0,1,10'h000,0, 3,10'h239,1,0,0);
    add(0,1,10'h000,0, 2,10'h04F,1,0,0);
    add(0,1,10'h000,0, 1,10'h04D,1,0,0);
    add(0,1,10'h000,0, 0,10'h018,1,0,0);
    add(0,0,10'h000,0, 0,10'h018,0,0,0);
    // Overflow and wrap (pointers start at 6 here).
    for (int k = 0; k < 8; k++) add(1,0,10'h100 + 10'(k),0, k+1,10'h018,0,0,0);
    add(1,0,10'h3FF,0, 8,10'h018,0,1,0);
    add(0,1,10'h000,0, 7,10'h100,1,1,0);
    add(0,1,10'h000,0, 6,10'h101,1,1,0);
    add(0,1,10'h000,0, 5,10'h102,1,1,0);
    add(0,1,10'h000,0, 4,10'h103,1,1,0);
    for (int k = 0; k < 4; k++) add(1,0,10'h110 + 10'(k),0, k+5,10'h103,0,1,0);
    add(0,0,10'h000,1, 8,10'h103,0,0,0);
    // Simultaneous push/pop at full.
    add(1,1,10'h155,0, 8,10'h104,1,0,0);
    add(0,1,10'h000,0, 7,10'h105,1,0,0);
    add(0,1,10'h000,0, 6,10'h106,1,0,0);
    add(0,1,10'h000,0, 5,10'h107,1,0,0);
    add(0,1,10'h000,0, 4,10'h110,1,0,0);
    add(0,1,10'h000,0, 3,10'h111,1,0,0);
    add(0,1,10'h000,0, 2,10'h112,1,0,0);
    add(0,1,10'h000,0, 1,10'h113,1,0,0);
    add(0,1,10'h000,0, 0,10'h155,1,0,0);
    // Underflow on empty, with and without push; clr_err priority.
    add(0,1,10'h000,0, 0,10'h155,0,0,1);
    add(1,1,10'h2AA,0, 1,10'h155,0,0,1);
    add(0,0,10'h000,1, 1,10'h155,0,0,0);
    add(0,1,10'h000,0, 0,10'h2AA,1,0,0);
    add(0,1,10'h000,1, 0,10'h2AA,0,0,0);
    add(0,1,10'h000,0, 0,10'h2AA,0,0,1);
    add(1,0,10'h3FF,1, 1,10'h2AA,0,0,0);

    // Reset and defaults.
    reset = 1'b0; push = 0; pop = 0; din = '0; clr_err = 0;
    af_thresh = 4'd6; ae_thresh = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 0, int'(fifo_count), 0);
    check("rst_empty", 0, int'(empty), 1);
    check("rst_almost_empty", 0, int'(almost_empty), 1);
    check("rst_full", 0, int'(full), 0);
    check("rst_almost_full", 0, int'(almost_full), 0);
    check("rst_data_out", 0, int'(dout), 0);
    check("rst_data_valid", 0, int'(data_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_count", 1, int'(fifo_count), 0);
    check("post_rst_empty", 1, int'(empty), 1);
    check("post_rst_valid", 1, int'(data_valid), 0);
    $display("[TB] reset released cnt=%0d empty=%0d", fifo_count, empty);

    // Table of vectors, one clock per record.
    for (int i = 0; i < nv; i++) begin
      push = vecs[i].push; pop = vecs[i].pop; din = vecs[i].din; clr_err = vecs[i].clr;
      @(posedge clk);
      #1;
      check_vec(i, vecs[i]);
    end
    push = 0; pop = 0; clr_err = 0;

    // Threshold boundaries with count = 1.
    af_thresh = 4'd0; ae_thresh = 4'd8;
    #1;
    check("af_thresh0", 0, int'(almost_full), 1);
    check("ae_thresh8", 0, int'(almost_empty), 1);
    af_thresh = 4'd1; ae_thresh = 4'd0;
    #1;
    check("af_eq_count", 0, int'(almost_full), 1);
    check("ae_below_count", 0, int'(almost_empty), 0);
    af_thresh = 4'd2;
    #1;
    check("af_above_count", 0, int'(almost_full), 0);
    $display("[TB] thresholds af=%0d ae=%0d cnt=%0d -> af_flag=%0d ae_flag=%0d",
             af_thresh, ae_thresh, fifo_count, almost_full, almost_empty);
    af_thresh = 4'd6; ae_thresh = 4'd1;

    // Reset mid-stream: bring occupancy to 5 then pulse reset between edges.
    for (int k = 0; k < 4; k++) begin
      push = 1; din = 10'h050 + 10'(k);
      @(posedge clk);
      #1;
    end
    push = 0;
    check("pre_rst_count", 0, int'(fifo_count), 5);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_empty", 0, int'(empty), 1);
    check("midrst_count", 0, int'(fifo_count), 0);
    check("midrst_data_out", 0, int'(dout), 0);
    #2;
    reset = 1'b1;
    pop = 1;
    @(posedge clk);
    #1;
    pop = 0;
    check("midrst_underflow", 0, int'(underflow_err), 1);
    check("midrst_valid", 0, int'(data_valid), 0);
    check("midrst_stale", 0, int'(dout), 0);
    check("midrst_count2", 0, int'(fifo_count), 0);
    $display("[TB] pop after mid-stream reset -> udf=%0d valid=%0d dout=%03h",
             underflow_err, data_valid, dout);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
